// File: rtl/mdu_seq.sv
// mdu_seq: EX-stage sequencer for multi-cycle multiply/divide units with HI/LO writeback
module mdu_seq #(
  parameter logic [31:0] DIV_ZERO_LO = 32'hFFFF_FFFF
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        flush,
  input  logic [5:0]  stall,
  input  logic        ex_op_valid,
  input  logic [1:0]  ex_op,
  input  logic [31:0] ex_src_a,
  input  logic [31:0] ex_src_b,
  output logic        mul_start,
  output logic        div_start,
  output logic        op_signed,
  output logic [31:0] op_a,
  output logic [31:0] op_b,
  output logic        unit_cancel,
  input  logic        mul_ready,
  input  logic        div_ready,
  input  logic [63:0] unit_result,
  output logic        stallreq_for_ex,
  output logic        hilo_we,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o,
  output logic        busy
);
  typedef enum logic [1:0] {IDLE, MUL_WAIT, DIV_WAIT, DONE} state_t;
  state_t state, state_nx;
  logic [31:0] hi_r, lo_r, a_r, b_r;
  logic sgn_r, accept, is_div, div_zero, waiting, capture;
  logic stall_unused;
  assign stall_unused = ^{stall[5:4], stall[2:0]};
  // next-state and outputs; resetn gates accept so every output is 0 while in reset
  always_comb begin
    is_div = ex_op[1];
    div_zero = is_div && (ex_src_b == 32'd0);
    accept = resetn && (state == IDLE) && ex_op_valid && !flush;
    waiting = (state == MUL_WAIT) || (state == DIV_WAIT);
    capture = !flush && (((state == MUL_WAIT) && mul_ready) || ((state == DIV_WAIT) && div_ready));
    mul_start = accept && !is_div;
    div_start = accept && is_div && !div_zero;
    op_signed = accept ? ~ex_op[0] : sgn_r;
    op_a = accept ? ex_src_a : a_r;
    op_b = accept ? ex_src_b : b_r;
    unit_cancel = flush && waiting;
    stallreq_for_ex = accept || waiting;
    hilo_we = (state == DONE) && !flush;
    hi_o = hi_r;
    lo_o = lo_r;
    busy = state != IDLE;
    state_nx = state;
    if (flush) state_nx = IDLE;
    else if (state == IDLE) state_nx = !accept ? IDLE : div_zero ? DONE : is_div ? DIV_WAIT : MUL_WAIT;
    else if (waiting) state_nx = capture ? DONE : state;
    else state_nx = stall[3] ? DONE : IDLE;
  end
  // state register, operand latches and HI/LO result capture
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= IDLE;
      hi_r <= '0;
      lo_r <= '0;
      a_r <= '0;
      b_r <= '0;
      sgn_r <= 1'b0;
    end else begin
      state <= state_nx;
      if (accept) begin
        a_r <= ex_src_a;
        b_r <= ex_src_b;
        sgn_r <= ~ex_op[0];
      end
      if (accept && div_zero) begin
        hi_r <= ex_src_a;
        lo_r <= DIV_ZERO_LO;
      end else if (capture) begin
        {hi_r, lo_r} <= unit_result;
      end
    end
  end
endmodule
